river_lane: RTL and testbench

RIVER_LANE -- requirements
Module: river_lane

---
 rtl/river_lane_if.sv | 29 ++
 rtl/river_lane.sv | 160 ++++++++++++++++
 tb/tb_river_lane.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/river_lane_if.sv
// Control inputs and pad/frog status outputs shared between a river lane and its
// controller. The lane is the slave side.
interface river_lane_if #(parameter int NUM_PADS = 4);
  logic                    Enable;
  logic                    Direction;
  logic [4:0]              Speed;
  logic                    Dive_En;
  logic [10:0]             Start_X;
  logic [10:0]             Lane_Y;
  logic [10:0]             Frog_X;
  logic [10:0]             Frog_Y;
  logic [11*NUM_PADS-1:0]  Pad_X;
  logic                    Pad_Visible;
  logic                    Pad_Warn;
  logic                    Frog_On_Pad;
  logic [2:0]              Pad_Index;
  logic [10:0]             Carry_Dx;
  logic                    Move_Tick;

  modport master (
    output Enable, Direction, Speed, Dive_En, Start_X, Lane_Y, Frog_X, Frog_Y,
    input  Pad_X, Pad_Visible, Pad_Warn, Frog_On_Pad, Pad_Index, Carry_Dx, Move_Tick
  );

  modport slave (
    input  Enable, Direction, Speed, Dive_En, Start_X, Lane_Y, Frog_X, Frog_Y,
    output Pad_X, Pad_Visible, Pad_Warn, Frog_On_Pad, Pad_Index, Carry_Dx, Move_Tick
  );
endinterface

// File: rtl/river_lane.sv
// River lane of lily pads scrolling with wrap-around, a periodic dive cycle and
// frog support/carry detection.
//   state | meaning
//   SURF  | pads visible, no warning
//   WARN  | pads visible, about to submerge
//   SUB   | pads submerged, nothing can be supported
module river_lane #(
  parameter int NUM_PADS  = 4,
  parameter int PAD_W     = 40,
  parameter int SPACING   = 170,
  parameter int STEP      = 10,
  parameter int SURF_T    = 8,
  parameter int WARN_T    = 3,
  parameter int SUB_T     = 4,
  parameter int FROG_SIDE = 40
) (
  input logic          frame_clk,
  input logic          Reset_n,
  river_lane_if.slave  lane
);
  localparam int WRAP = 640 + PAD_W;
  localparam logic signed [12:0] HALF_S = 13'(FROG_SIDE / 2);
  localparam logic signed [12:0] PADW_S = 13'(PAD_W);

  typedef enum logic [1:0] {SURF, WARN, SUB} dive_t;

  dive_t        state;
  logic [7:0]   pc;
  logic         pad_visible, pad_warn;
  logic [10:0]  ofs, ofs_next, start_mod;
  logic [11:0]  up_sum;
  logic [4:0]   tc;
  logic         tick_now, move_tick, tick_dir;
  logic         frog_on;
  logic [2:0]   frog_idx;

  logic [11*NUM_PADS-1:0] pad_bus;
  logic [NUM_PADS-1:0]    hit;
  logic signed [12:0]     centre;
  logic [11:0]            lane_bot;
  logic                   row_ok;
  logic                   found;
  logic [2:0]             found_idx;

  assign start_mod = 11'(int'(lane.Start_X) % WRAP);

  // >= rather than == so a Speed lowered below the running count fires next frame
  assign tick_now = lane.Enable && (tc >= lane.Speed);
  assign up_sum   = {1'b0, ofs} + 12'(STEP);

  always_comb begin
    ofs_next = ofs;
    if (lane.Direction)
      ofs_next = (up_sum >= 12'(WRAP)) ? 11'(up_sum - 12'(WRAP)) : up_sum[10:0];
    else
      ofs_next = (ofs < 11'(STEP)) ? ofs + 11'(WRAP - STEP) : ofs - 11'(STEP);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ofs       <= start_mod;
      tc        <= '0;
      move_tick <= 1'b0;
      tick_dir  <= 1'b0;
    end else begin
      move_tick <= tick_now;
      if (tick_now) begin
        tc       <= '0;
        ofs      <= ofs_next;
        tick_dir <= lane.Direction;
      end else if (lane.Enable) begin
        tc <= tc + 5'd1;
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= SURF;
      pc          <= '0;
      pad_visible <= 1'b1;
      pad_warn    <= 1'b0;
    end else if (!lane.Dive_En) begin
      state       <= SURF;
      pc          <= '0;
      pad_visible <= 1'b1;
      pad_warn    <= 1'b0;
    end else if (tick_now) begin
      case (state)
        SURF: if (pc == 8'(SURF_T - 1)) begin
                state    <= WARN;
                pc       <= '0;
                pad_warn <= 1'b1;
              end else pc <= pc + 8'd1;
        WARN: if (pc == 8'(WARN_T - 1)) begin
                state       <= SUB;
                pc          <= '0;
                pad_warn    <= 1'b0;
                pad_visible <= 1'b0;
              end else pc <= pc + 8'd1;
        SUB:  if (pc == 8'(SUB_T - 1)) begin
                state       <= SURF;
                pc          <= '0;
                pad_visible <= 1'b1;
              end else pc <= pc + 8'd1;
        default: begin
                state       <= SURF;
                pc          <= '0;
                pad_visible <= 1'b1;
                pad_warn    <= 1'b0;
              end
      endcase
    end
  end

  assign centre   = $signed({2'b00, lane.Frog_X}) + HALF_S;
  assign lane_bot = {1'b0, lane.Lane_Y} + 12'(PAD_W);
  assign row_ok   = (lane.Frog_Y >= lane.Lane_Y) && ({1'b0, lane.Frog_Y} < lane_bot);

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    localparam int BASE = (g * SPACING) % WRAP;
    logic [11:0]        raw;
    logic [10:0]        px;
    logic signed [12:0] px_s;
    assign raw  = {1'b0, ofs} + 12'(BASE);
    assign px   = ((raw >= 12'(WRAP)) ? 11'(raw - 12'(WRAP)) : raw[10:0]) - 11'(PAD_W);
    assign px_s = $signed({{2{px[10]}}, px});
    assign pad_bus[11*g +: 11] = px;
    assign hit[g] = (centre >= px_s) && (centre < px_s + PADW_S);
  end

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (hit[i] && row_ok && pad_visible) begin
        found     = 1'b1;
        found_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frog_on  <= 1'b0;
      frog_idx <= '0;
    end else begin
      frog_on <= found;
      if (found) frog_idx <= found_idx;
    end
  end

  assign lane.Pad_X       = pad_bus;
  assign lane.Pad_Visible = pad_visible;
  assign lane.Pad_Warn    = pad_warn;
  assign lane.Frog_On_Pad = frog_on;
  assign lane.Pad_Index   = frog_idx;
  assign lane.Move_Tick   = move_tick;
  assign lane.Carry_Dx    = (move_tick && frog_on) ? (tick_dir ? 11'(STEP) : 11'(-STEP)) : 11'd0;
endmodule

// File: tb/tb_river_lane.sv
// Randomized scoreboard bench for river_lane against an arithmetic lane model.
module tb_river_lane;
  localparam int NUM_PADS = 4, PAD_W = 40, SPACING = 170, STEP = 10;
  localparam int SURF_T = 8, WARN_T = 3, SUB_T = 4, FROG_SIDE = 40;
  localparam int WRAP = 640 + PAD_W;
  localparam int DIVE_P = SURF_T + WARN_T + SUB_T;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;

  river_lane_if #(.NUM_PADS(NUM_PADS)) lane();

  river_lane #(.NUM_PADS(NUM_PADS), .PAD_W(PAD_W), .SPACING(SPACING), .STEP(STEP),
               .SURF_T(SURF_T), .WARN_T(WARN_T), .SUB_T(SUB_T), .FROG_SIDE(FROG_SIDE))
    dut (.frame_clk(frame_clk), .Reset_n(Reset_n), .lane(lane));

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [11*NUM_PADS-1:0] padx;
    logic        vis;
    logic        warn;
    logic        on;
    logic [2:0]  idx;
    logic [10:0] carry;
    logic        tick;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  int m_ofs, m_tc, m_dcnt, m_idx, m_carry;
  bit m_tick, m_on;

  function automatic int pad_left(int i);
    return ((m_ofs + i * SPACING) % WRAP) - PAD_W;
  endfunction

  function automatic bit m_vis();
    return m_dcnt < SURF_T + WARN_T;
  endfunction

  function automatic bit m_warn();
    return (m_dcnt >= SURF_T) && (m_dcnt < SURF_T + WARN_T);
  endfunction

  task automatic model_reset(input int start);
    m_ofs = start % WRAP; m_tc = 0; m_dcnt = 0;
    m_tick = 0; m_on = 0; m_idx = 0; m_carry = 0;
  endtask

  task automatic model_step();
    bit found = 0;
    int fi = 0;
    int centre = int'(lane.Frog_X) + FROG_SIDE / 2;
    bit rowok = (lane.Frog_Y >= lane.Lane_Y) && (int'(lane.Frog_Y) < int'(lane.Lane_Y) + PAD_W);
    bit tick = lane.Enable && (m_tc >= int'(lane.Speed));
    for (int i = NUM_PADS - 1; i >= 0; i--)
      if (m_vis() && rowok && centre >= pad_left(i) && centre < pad_left(i) + PAD_W) begin
        found = 1; fi = i;
      end
    if (tick) begin
      m_tc  = 0;
      m_ofs = lane.Direction ? (m_ofs + STEP) % WRAP : (m_ofs - STEP + WRAP) % WRAP;
    end else if (lane.Enable) m_tc++;
    if (!lane.Dive_En) m_dcnt = 0;
    else if (tick) m_dcnt = (m_dcnt + 1) % DIVE_P;
    m_tick = tick;
    m_on   = found;
    if (found) m_idx = fi;
    m_carry = (tick && found) ? (lane.Direction ? STEP : -STEP) : 0;
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    for (int i = 0; i < NUM_PADS; i++) e.padx[11*i +: 11] = 11'(pad_left(i));
    e.vis = m_vis(); e.warn = m_warn(); e.on = m_on;
    e.idx = 3'(m_idx); e.carry = 11'(m_carry); e.tick = m_tick;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("pad_x",   64'(lane.Pad_X),       64'(e.padx));
    chk("visible", 64'(lane.Pad_Visible), 64'(e.vis));
    chk("warn",    64'(lane.Pad_Warn),    64'(e.warn));
    chk("on_pad",  64'(lane.Frog_On_Pad), 64'(e.on));
    chk("index",   64'(lane.Pad_Index),   64'(e.idx));
    chk("carry",   64'(lane.Carry_Dx),    64'(e.carry));
    chk("tick",    64'(lane.Move_Tick),   64'(e.tick));
  endtask

  // monitor: one expected record per clock edge
  always begin
    @(posedge frame_clk);
    #1;
    if (q.size() > 0) compare(q.pop_front());
  end

  // called at a negedge with inputs already driven; model the coming edge
  task automatic step();
    if (!Reset_n) model_reset(int'(lane.Start_X));
    else model_step();
    q.push_back(make_exp());
    @(negedge frame_clk);
  endtask

  task automatic do_reset(input int start, input int n);
    lane.Start_X = 11'(start);
    Reset_n = 1'b0;
    #1;
    model_reset(start);
    compare(make_exp());
    for (int i = 0; i < n; i++) step();
    Reset_n = 1'b1;
  endtask

  task automatic check_pad0(input string name, input int exp);
    chk(name, 64'($signed(lane.Pad_X[10:0])), 64'(exp));
  endtask

  initial begin
    int fx, fy;
    lane.Enable = 1; lane.Direction = 1; lane.Speed = 5'd2; lane.Dive_En = 0;
    lane.Start_X = 0; lane.Lane_Y = 11'd100; lane.Frog_X = 0; lane.Frog_Y = 0;
    model_reset(0);
    q.push_back(make_exp());
    @(negedge frame_clk);

    do_reset(0, 1);
    for (int i = 0; i < 3; i++) step();
    check_pad0("scroll_1", -30);
    for (int i = 0; i < 3; i++) step();
    check_pad0("scroll_2", -20);

    lane.Direction = 0; lane.Speed = 0;
    do_reset(5, 1);
    step();
    check_pad0("left_wrap", 635);

    lane.Direction = 1;
    do_reset(675, 1);
    step();
    check_pad0("right_wrap", -35);

    lane.Frog_X = 11'd300; lane.Frog_Y = 11'd100;
    do_reset(0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pad2_on", 64'(lane.Frog_On_Pad), 64'd1);
      chk("pad2_idx", 64'(lane.Pad_Index), 64'd2);
      chk("pad2_carry", 64'(lane.Carry_Dx), 64'd10);
    end

    lane.Dive_En = 1; lane.Frog_X = 11'd0;
    do_reset(0, 1);
    for (int i = 0; i < 20; i++) step();
    do_reset(0, 1);
    for (int i = 0; i < 9; i++) step();
    chk("mid_warn", 64'(lane.Pad_Warn), 64'd1);
    do_reset(123, 2);
    check_pad0("reset_ofs", 83);

    for (int n = 0; n < 1500; n++) begin
      lane.Enable = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) lane.Direction = ~lane.Direction;
      if ($urandom % 32 == 0) lane.Speed = 5'($urandom % 6);
      if ($urandom % 40 == 0) lane.Dive_En = ~lane.Dive_En;
      if ($urandom % 4 == 0) begin
        fx = pad_left(int'($urandom % NUM_PADS)) - FROG_SIDE / 2 + int'($urandom_range(0, 60)) - 10;
        fy = 100 + int'($urandom_range(0, 50)) - 5;
        lane.Frog_X = 11'((fx < 0) ? 0 : fx);
        lane.Frog_Y = 11'(fy);
      end
      if ($urandom % 400 == 0) do_reset(int'($urandom_range(0, 2047)), 1);
      else step();
    end

    @(posedge frame_clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
